// File: rtl/sample_gather8.sv
// sample_gather8: packs a serial valid/ready stream of signed samples into an
// 8-lane window (a..h, in arrival order) and holds it, with its sample count on
// num, until downstream accepts it. A flush request closes a partial window;
// lanes that were never filled are zero.
//
// Optional build macro SG_TIMEOUT_EN: adds a 16-bit idle counter that issues an
// implicit flush after TIMEOUT idle FILL cycles while a partial window is open.
module sample_gather8 #(
  parameter int DATAW   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DATAW-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [DATAW-1:0] a,
  output logic [DATAW-1:0] b,
  output logic [DATAW-1:0] c,
  output logic [DATAW-1:0] d,
  output logic [DATAW-1:0] e,
  output logic [DATAW-1:0] f,
  output logic [DATAW-1:0] g,
  output logic [DATAW-1:0] h,
  output logic [DATAW-1:0] num,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       num_q, num_d;
  logic [DATAW-1:0] lane_q [8];
  logic [DATAW-1:0] lane_d [8];

  logic accept;
  logic flush_eff;
  logic timeout_hit;

  // Handshake flags decode from state only, never from in_valid.
  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign flush_eff = flush || timeout_hit;

`ifdef SG_TIMEOUT_EN
  logic [15:0] idle_q;

  assign timeout_hit = (state_q == FILL) && (idx_q != 3'd0) && (idle_q == 16'(TIMEOUT));

  // Idle counter: runs only while a partial window sits in FILL untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_q <= '0;
    end else if (accept || (idx_q == 3'd0) || (state_q != FILL) || timeout_hit) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + 16'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and next-window computation.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    lane_d  = lane_q;

    unique case (state_q)
      FILL: begin
        if (accept) begin
          lane_d[idx_q] = in_data;
          idx_d         = idx_q + 3'd1;
        end
        if (accept && (idx_q == 3'd7)) begin
          // Eighth sample completes the window whether or not flush is set.
          state_d = HOLD;
          num_d   = 4'd8;
          idx_d   = 3'd0;
        end else if (accept && flush_eff) begin
          // Sample is stored first, then the window closes around it.
          state_d = HOLD;
          num_d   = {1'b0, idx_q} + 4'd1;
          idx_d   = 3'd0;
        end else if (flush_eff && (idx_q != 3'd0)) begin
          state_d = HOLD;
          num_d   = {1'b0, idx_q};
          idx_d   = 3'd0;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
          num_d   = 4'd0;
          idx_d   = 3'd0;
          for (int i = 0; i < 8; i++) begin
            lane_d[i] = '0;
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and window registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      idx_q   <= 3'd0;
      num_q   <= 4'd0;
      // NOTE: the eight lanes are ordinary flops, not a RAM, so they take the
      // reset; that is what guarantees zeros in unfilled lanes.
      for (int i = 0; i < 8; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above.
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      for (int i = 0; i < 8; i++) begin
        lane_q[i] <= lane_d[i];
      end
    end
  end

  assign a   = lane_q[0];
  assign b   = lane_q[1];
  assign c   = lane_q[2];
  assign d   = lane_q[3];
  assign e   = lane_q[4];
  assign f   = lane_q[5];
  assign g   = lane_q[6];
  assign h   = lane_q[7];
  assign num = {{(DATAW-4){1'b0}}, num_q};

endmodule
